// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - four-step control sequencer for a 4-register ALU datapath
//
// Ports:
//   CLKb    in   1   clock; state and IR update on the rising edge
//   Reset   in   1   synchronous active-high reset
//   Instr   in  10   instruction word {opcode[9:6], Rx[5:4], Ry[3:2]} / imm4 = [3:0]
//   Enw     in   1   instruction valid, sampled only in T0
//   Rin     out  4   one-hot register load enable
//   Rout    out  4   one-hot register bus-drive enable
//   Ain     out  1   ALU A-latch enable
//   Gin     out  1   ALU G-latch enable
//   Gout    out  1   G bus-drive enable
//   FN      out  4   ALU function select
//   ImmOut  out  1   immediate bus-drive enable
//   Imm     out 10   zero-extended imm4 from IR, always driven
//   Done    out  1   final step of the current instruction
//   Step    out  2   current step, 0=T0 .. 3=T3
module control_sequencer (
    input  logic       CLKb,
    input  logic       Reset,
    input  logic [9:0] Instr,
    input  logic       Enw,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] FN,
    output logic       ImmOut,
    output logic [9:0] Imm,
    output logic       Done,
    output logic [1:0] Step
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_BINARY,
        C_IMM,
        C_UNARY,
        C_SHIFT,
        C_LOAD,
        C_ILLEGAL
    } iclass_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] ir;
    iclass_t    iclass;

    logic [3:0] op;
    logic [1:0] rx;
    logic [1:0] ry;
    logic [3:0] rx_hot;
    logic [3:0] ry_hot;

    assign op     = ir[9:6];
    assign rx     = ir[5:4];
    assign ry     = ir[3:2];
    assign rx_hot = 4'b0001 << rx;
    assign ry_hot = 4'b0001 << ry;
    assign Imm    = {6'b0, ir[3:0]};
    assign Step   = state;

    always_comb begin
        iclass = C_ILLEGAL;
        case (op)
            4'b0000:                            iclass = C_LOAD;
            4'b0001, 4'b0100, 4'b0101:          iclass = C_UNARY;
            4'b0010, 4'b0011, 4'b0110,
            4'b0111, 4'b1000:                   iclass = C_BINARY;
            4'b1001, 4'b1010, 4'b1011:          iclass = C_SHIFT;
            4'b1100, 4'b1101:                   iclass = C_IMM;
            default:                            iclass = C_ILLEGAL;
        endcase
    end

    always_ff @(posedge CLKb) begin
        if (Reset) begin
            state <= T0;
            ir    <= 10'd0;
        end else begin
            state <= state_nxt;
            // IR is only loaded on an accept so later Instr changes cannot disturb execution
            if (state == T0 && Enw) begin
                ir <= Instr;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            T0: state_nxt = Enw ? T1 : T0;
            T1: state_nxt = (iclass == C_ILLEGAL) ? T0 : T2;
            // shift and load finish in T2 and skip T3
            T2: state_nxt = (iclass == C_SHIFT || iclass == C_LOAD) ? T0 : T3;
            T3: state_nxt = T0;
            default: state_nxt = T0;
        endcase
    end

    always_comb begin
        Rin    = 4'b0000;
        Rout   = 4'b0000;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        FN     = 4'b0000;
        ImmOut = 1'b0;
        Done   = 1'b0;
        case (state)
            T1: begin
                case (iclass)
                    C_BINARY, C_UNARY: begin
                        Rout = ry_hot;
                        Ain  = 1'b1;
                    end
                    C_IMM: begin
                        ImmOut = 1'b1;
                        Ain    = 1'b1;
                    end
                    C_SHIFT: begin
                        Rout = ry_hot;
                        FN   = op;
                        Gin  = 1'b1;
                    end
                    C_LOAD: begin
                        // load passes the immediate through the ALU with FN=0000
                        ImmOut = 1'b1;
                        Gin    = 1'b1;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                case (iclass)
                    C_BINARY, C_IMM: begin
                        Rout = rx_hot;
                        FN   = op;
                        Gin  = 1'b1;
                    end
                    C_UNARY: begin
                        FN  = op;
                        Gin = 1'b1;
                    end
                    C_SHIFT, C_LOAD: begin
                        Gout = 1'b1;
                        Rin  = rx_hot;
                        Done = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                if (iclass == C_BINARY || iclass == C_IMM || iclass == C_UNARY) begin
                    Gout = 1'b1;
                    Rin  = rx_hot;
                    Done = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    typedef struct packed {
        logic [3:0] rin;
        logic [3:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] fn;
        logic       immout;
        logic [9:0] imm;
        logic       done;
        logic [1:0] step;
    } outv_t;

    logic       CLKb = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] Instr = 10'd0;
    logic       Enw = 1'b0;
    logic [3:0] Rin;
    logic [3:0] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [3:0] FN;
    logic       ImmOut;
    logic [9:0] Imm;
    logic       Done;
    logic [1:0] Step;

    outv_t act;
    outv_t exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;
    bit    armed = 1'b0;

    control_sequencer dut (
        .CLKb   (CLKb),
        .Reset  (Reset),
        .Instr  (Instr),
        .Enw    (Enw),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .FN     (FN),
        .ImmOut (ImmOut),
        .Imm    (Imm),
        .Done   (Done),
        .Step   (Step)
    );

    always #5 CLKb = ~CLKb;

    assign act = {Rin, Rout, Ain, Gin, Gout, FN, ImmOut, Imm, Done, Step};

    function automatic outv_t ev(input logic [3:0] rin, input logic [3:0] rout,
                                 input logic ain, input logic gin, input logic gout,
                                 input logic [3:0] fn, input logic immout,
                                 input logic [9:0] imm, input logic done,
                                 input logic [1:0] step);
        ev = {rin, rout, ain, gin, gout, fn, immout, imm, done, step};
    endfunction

    function automatic outv_t idle(input logic [9:0] imm);
        idle = ev(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, imm, 1'b0, 2'd0);
    endfunction

    // apply inputs, clock once, then queue what the outputs must be after that edge
    task automatic cyc(input logic rst, input logic enw, input logic [9:0] instr,
                       input outv_t e, input string nm);
        Reset = rst;
        Enw   = enw;
        Instr = instr;
        @(posedge CLKb);
        #1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge CLKb) begin
        outv_t e;
        string nm;
        if (armed) begin
            total++;
            if (($countones(Rout) + 32'(ImmOut) + 32'(Gout)) > 1) begin
                bad++;
                $display("FAIL bus_excl: Rout=%b ImmOut=%b Gout=%b, required at most one driver",
                         Rout, ImmOut, Gout);
            end
            total++;
            if ($countones(Rin) > 1) begin
                bad++;
                $display("FAIL rin_onehot: Rin=%b, required at most one bit", Rin);
            end
            total++;
            if (!Gin && FN != 4'b0000) begin
                bad++;
                $display("FAIL fn_idle: FN=%b with Gin=0, required 0000", FN);
            end
        end
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got Rin=%b Rout=%b Ain=%b Gin=%b Gout=%b FN=%b ImmOut=%b Imm=%b Done=%b Step=%0d, required Rin=%b Rout=%b Ain=%b Gin=%b Gout=%b FN=%b ImmOut=%b Imm=%b Done=%b Step=%0d",
                         nm, act.rin, act.rout, act.ain, act.gin, act.gout, act.fn, act.immout,
                         act.imm, act.done, act.step, e.rin, e.rout, e.ain, e.gin, e.gout, e.fn,
                         e.immout, e.imm, e.done, e.step);
            end
        end
    end

    localparam logic [9:0] ADD_R1_R2  = 10'b0010_01_10_00;
    localparam logic [9:0] ADDI_R3_5  = 10'b1100_11_0101;
    localparam logic [9:0] LSL_R0_R2  = 10'b1001_00_10_00;
    localparam logic [9:0] LD_R2_7    = 10'b0000_10_0111;
    localparam logic [9:0] NEG_R0_R3  = 10'b0100_00_11_00;
    localparam logic [9:0] OR_R2_R2   = 10'b0111_10_10_00;
    localparam logic [9:0] SUB_R1_R2  = 10'b0011_01_10_00;
    localparam logic [9:0] XOR_R3_R0  = 10'b1000_11_00_01;
    localparam logic [9:0] ILL        = 10'b1111_00_00_00;

    initial begin
        // reset held two cycles while an add is offered: nothing is accepted
        cyc(1'b1, 1'b1, ADD_R1_R2, idle(10'd0), "reset_c1");
        armed = 1'b1;
        cyc(1'b1, 1'b1, ADD_R1_R2, idle(10'd0), "reset_c2");
        cyc(1'b0, 1'b0, ADD_R1_R2, idle(10'd0), "idle_no_enw");

        // add R1,R2 with Enw high and junk Instr during T1-T3
        cyc(1'b0, 1'b1, ADD_R1_R2, ev(4'b0000, 4'b0100, 1, 0, 0, 4'b0000, 0, 10'd8, 0, 2'd1), "add_t1");
        cyc(1'b0, 1'b1, ILL,       ev(4'b0000, 4'b0010, 0, 1, 0, 4'b0010, 0, 10'd8, 0, 2'd2), "add_t2");
        cyc(1'b0, 1'b1, ILL,       ev(4'b0010, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd8, 1, 2'd3), "add_t3");
        cyc(1'b0, 1'b0, ILL,       idle(10'd8), "add_t0");

        // addi R3,#5
        cyc(1'b0, 1'b1, ADDI_R3_5, ev(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 1, 10'd5, 0, 2'd1), "addi_t1");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0000, 4'b1000, 0, 1, 0, 4'b1100, 0, 10'd5, 0, 2'd2), "addi_t2");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b1000, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd5, 1, 2'd3), "addi_t3");
        cyc(1'b0, 1'b0, 10'd0,     idle(10'd5), "addi_t0");

        // lsl R0,R2: two steps, T3 skipped
        cyc(1'b0, 1'b1, LSL_R0_R2, ev(4'b0000, 4'b0100, 0, 1, 0, 4'b1001, 0, 10'd8, 0, 2'd1), "lsl_t1");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0001, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd8, 1, 2'd2), "lsl_t2");
        cyc(1'b0, 1'b0, 10'd0,     idle(10'd8), "lsl_t0");

        // load R2,#7 with back-to-back accept right after Done
        cyc(1'b0, 1'b1, LD_R2_7,   ev(4'b0000, 4'b0000, 0, 1, 0, 4'b0000, 1, 10'd7, 0, 2'd1), "ld_t1");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0100, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd7, 1, 2'd2), "ld_t2");
        cyc(1'b0, 1'b1, NEG_R0_R3, idle(10'd7), "ld_t0");

        // negate R0,R3 accepted in the T0 that followed load
        cyc(1'b0, 1'b1, NEG_R0_R3, ev(4'b0000, 4'b1000, 1, 0, 0, 4'b0000, 0, 10'd12, 0, 2'd1), "neg_t1");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0000, 4'b0000, 0, 1, 0, 4'b0100, 0, 10'd12, 0, 2'd2), "neg_t2");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0001, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd12, 1, 2'd3), "neg_t3");
        cyc(1'b0, 1'b0, 10'd0,     idle(10'd12), "neg_t0");

        // or R2,R2: Rx==Ry
        cyc(1'b0, 1'b1, OR_R2_R2,  ev(4'b0000, 4'b0100, 1, 0, 0, 4'b0000, 0, 10'd8, 0, 2'd1), "or_t1");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0000, 4'b0100, 0, 1, 0, 4'b0111, 0, 10'd8, 0, 2'd2), "or_t2");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0100, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd8, 1, 2'd3), "or_t3");
        cyc(1'b0, 1'b0, 10'd0,     idle(10'd8), "or_t0");

        // sub R1,R2 aborted by reset at the T2 edge, then xor R3,R0 runs normally
        cyc(1'b0, 1'b1, SUB_R1_R2, ev(4'b0000, 4'b0100, 1, 0, 0, 4'b0000, 0, 10'd8, 0, 2'd1), "sub_t1");
        cyc(1'b1, 1'b1, SUB_R1_R2, idle(10'd0), "sub_abort");
        cyc(1'b0, 1'b1, XOR_R3_R0, ev(4'b0000, 4'b0001, 1, 0, 0, 4'b0000, 0, 10'd1, 0, 2'd1), "xor_t1");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b0000, 4'b1000, 0, 1, 0, 4'b1000, 0, 10'd1, 0, 2'd2), "xor_t2");
        cyc(1'b0, 1'b0, 10'd0,     ev(4'b1000, 4'b0000, 0, 0, 1, 4'b0000, 0, 10'd1, 1, 2'd3), "xor_t3");
        cyc(1'b0, 1'b0, 10'd0,     idle(10'd1), "xor_t0");

        // illegal opcode with Enw held high: accepts every second cycle
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, ILL, ev(4'b0000, 4'b0000, 0, 0, 0, 4'b0000, 0, 10'd0, 1, 2'd1), "ill_t1");
            cyc(1'b0, 1'b1, ILL, idle(10'd0), "ill_t0");
        end
        cyc(1'b0, 1'b0, 10'd0, idle(10'd0), "final_idle");

        repeat (2) @(posedge CLKb);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL: CLKb, input, 1, the only clock; the state register and IR update on the rising edge.
REQ-002 SHALL: Reset, input, 1, synchronous and active-high; one clock; sampled on the CLKb rising edge.
REQ-003 SHALL: Instr, input, 10, instruction word; IR[9:6]=opcode (ALU FN code), IR[5:4]=Rx (destination), IR[3:2]=Ry (source), IR[3:0]=imm4.
REQ-004 SHALL: Enw, input, 1, instruction valid; sampled only in T0.
REQ-005 SHALL: Rin, output, 4, one-hot register load enable, bit n = Rn.
REQ-006 SHALL: Rout, output, 4, one-hot register bus-drive enable, bit n = Rn.
REQ-007 SHALL: Ain, Gin, Gout, outputs, 1 each, ALU A-latch, G-latch and G-drive enables.
REQ-008 SHALL: FN, output, 4, ALU function select.
REQ-009 SHALL: ImmOut, output, 1, immediate bus-drive enable; Imm, output, 10, value {6'b0, IR[3:0]}, driven at all times.
REQ-010 SHALL: Done, output, 1, asserted in the final step of an instruction; Step, output, 2, current step (0=T0..3=T3).

Function
REQ-011 SHALL: the FSM has states T0 (idle), T1, T2 and T3; all outputs are combinational from state and IR, so they are stable before the next CLKb falling edge.
REQ-012 SHALL: in T0 with Enw=1, IR<=Instr and the FSM goes to T1; with Enw=0 it stays in T0; IR changes only on this accept; T0 drives all enables 0.
REQ-013 SHALL: binary class (0010 add, 0011 sub, 0110 and, 0111 or, 1000 xor):
- T1: Rout[Ry], Ain.
- T2: Rout[Rx], FN=op, Gin.
- T3: Gout, Rin[Rx], Done.
- Result is Rx op Ry; sub yields Rx-Ry.
REQ-014 SHALL: immediate class (1100 addi, 1101 subi):
- T1: ImmOut, Ain.
- T2: Rout[Rx], FN=op, Gin.
- T3: Gout, Rin[Rx], Done.
REQ-015 SHALL: unary class (0001 copy, 0100 negate, 0101 invert):
- T1: Rout[Ry], Ain.
- T2: FN=op, Gin; no bus driver.
- T3: Gout, Rin[Rx], Done.
REQ-016 SHALL: shift class (1001 lsl, 1010 lsr, 1011 asr):
- T1: Rout[Ry], FN=op, Gin.
- T2: Gout, Rin[Rx], Done.
- Then T0; T3 is not visited.
REQ-017 SHALL: load (0000):
- T1: ImmOut, FN=0000, Gin.
- T2: Gout, Rin[Rx], Done.
- Then T0.
REQ-018 SHALL: illegal opcodes (1110, 1111):
- T1: Done=1, all enables 0.
- Then T0; no register is written.
REQ-019 SHALL: after the Done step the FSM returns to T0; the earliest next accept is one cycle after Done (T0 with Enw=1).
REQ-020 SHALL: in every state at most one of {any Rout bit, ImmOut, Gout} is 1, and Rin has at most one bit set.
REQ-021 SHALL: FN=0000 whenever Gin=0.
REQ-022 SHALL: Rx==Ry is legal and uses the same sequences unchanged.
REQ-023 SHALL: Enw is ignored in T1-T3; Instr changes during T1-T3 have no effect.

Reset
REQ-024 SHALL: Reset=1 at a rising edge forces state T0 and IR=0, with Rin=0, Rout=0, Ain=Gin=Gout=0, FN=0000, ImmOut=0, Done=0, Step=0.
REQ-025 SHALL: Reset has priority over Enw and aborts an in-flight instruction; no Rin or Gout is asserted in the cycle after reset.

Verification
REQ-026 SHALL: Reset held 2 cycles with Enw=1, Instr=0010011000 -> Step=0, all enables 0, Done=0; no accept occurs.
REQ-027 SHALL: add R1,R2 (Instr=0010011000, Enw=1 in T0) -> T1 Rout=0100, Ain=1; T2 Rout=0010, FN=0010, Gin=1; T3 Gout=1, Rin=0010, Done=1; next cycle Step=0.
REQ-028 SHALL: addi R3,#5 (Instr=1100110101) -> T1 ImmOut=1, Imm=0000000101, Ain=1; T2 Rout=1000, FN=1100, Gin=1; T3 Gout=1, Rin=1000, Done=1.
REQ-029 SHALL: lsl R0,R2 (Instr=1001001000) -> T1 Rout=0100, FN=1001, Gin=1; T2 Gout=1, Rin=0001, Done=1; then T0; T3 is never visited.
REQ-030 SHALL: sub R1,R2 with Reset=1 at the T2 edge -> next cycle Step=0, IR=0, Gout=0, Rin=0000; a following accept of a new Instr executes normally.
REQ-031 SHALL: Instr=1111000000 with Enw held high continuously -> T1 Done=1, all enables 0; accepts occur only in T0 (every 2nd cycle); the bus-exclusivity check (REQ-020) holds in every cycle of every test.
